// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM link (transmit and receive sides).
package tdm_pkg;

    localparam int TDM_W = 8;
    localparam int TDM_N = 4;

    function automatic int ch_idx_w(input int n);
        return $clog2(n);
    endfunction

    typedef logic [ch_idx_w(TDM_N)-1:0] ch_idx_t;

endpackage

// File: rtl/tdm_demux_slot.sv
// One-entry output buffer for a single demux channel.
module tdm_demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // A write in the same cycle as a drain keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en_i) begin
            valid_d = 1'b1;
            data_d  = wr_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/tdm_stream_demux.sv
// Receive-side TDM demux: steers round-robin words to per-channel buffers
// and flags start-of-frame misalignment.
module tdm_stream_demux
    import tdm_pkg::*;
#(
    parameter int W = TDM_W,
    parameter int N = TDM_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_sof,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
    output logic           sof_err
);

    localparam int CW = ch_idx_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic [CW-1:0] tgt;
    logic          accept;
    logic [N-1:0]  wr_en;
    logic          sof_err_q;
    logic          sof_err_d;

    assign tgt      = in_sof ? '0 : ptr_q;
    assign in_ready = !out_valid[tgt] || out_ready[tgt];
    assign accept   = in_valid && in_ready;

    always_comb begin
        wr_en      = '0;
        wr_en[tgt] = accept;
    end

    // Explicit wrap keeps ptr below N for non-power-of-2 channel counts.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (tgt == LAST) ? '0 : tgt + 1'b1;
        end
    end

    assign sof_err_d = accept && in_sof && (ptr_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            sof_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign sof_err = sof_err_q;

    for (genvar i = 0; i < N; i++) begin : g_slot
        tdm_demux_slot #(
            .W(W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[i]),
            .wr_data_i (in_data),
            .valid_o   (out_valid[i]),
            .ready_i   (out_ready[i]),
            .data_o    (out_data[i*W +: W])
        );
    end

endmodule
